// File: rtl/regfile_writeback_arbiter.sv
// rtl/regfile_writeback_arbiter.sv - register-file write port merging WB-stage and long-latency writes; optional WB_WAW_SQUASH_EN
module regfile_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ALUWrite_IN,
  input  logic [4:0]  ALUWriteRegister_IN,
  input  logic [31:0] ALUWriteData_IN,
  input  logic        LongValid_IN,
  output logic        LongReady_OUT,
  input  logic [4:0]  LongWriteRegister_IN,
  input  logic [31:0] LongWriteData_IN,
  output logic        WriteEnable_OUT,
  output logic [4:0]  WriteRegister_OUT,
  output logic [31:0] WriteData_OUT,
  output logic [31:0] PendingMask_OUT,
  output logic        StallReq_OUT
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  // FIFO storage; occupancy is tracked per slot so full/empty fall out of the pointers' slots
  logic [4:0]       reg_q [DEPTH];
  logic [31:0]      dat_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] dead_q, dead_d;
  logic [DEPTH-1:0] squash_hit;
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    starve_q, starve_d;
  logic             we_q, we_d, stall_q, stall_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdat_q, wdat_d;
  logic             alu_eff, push, pop, fifo_full, fifo_empty;

  // Handshake and arbitration: an effective ALU write always wins the port
  always_comb begin
    alu_eff       = ALUWrite_IN && (ALUWriteRegister_IN != 5'd0);
    fifo_full     = vld_q[wr_q];
    fifo_empty    = !vld_q[rd_q];
    LongReady_OUT = !fifo_full && !RESET;
    push          = LongValid_IN && LongReady_OUT && (LongWriteRegister_IN != 5'd0);
    pop           = !alu_eff && !fifo_empty;
  end

`ifdef WB_WAW_SQUASH_EN
  // Buffered entries overwritten by this cycle's ALU write become dead
  always_comb begin
    squash_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash_hit[i] = alu_eff && vld_q[i] && (reg_q[i] == ALUWriteRegister_IN);
    end
  end
`else
  // Without squashing every buffered entry writes when popped
  always_comb begin
    squash_hit = '0;
  end
`endif

  // Next state for FIFO occupancy, write port, and starvation tracking
  always_comb begin
    vld_d  = vld_q;
    dead_d = dead_q | squash_hit;
    rd_d   = rd_q;
    wr_d   = wr_q;
    we_d   = 1'b0;
    wreg_d = wreg_q;
    wdat_d = wdat_q;
    if (pop) begin
      vld_d[rd_q]  = 1'b0;
      dead_d[rd_q] = 1'b0;
      rd_d         = rd_q + AW'(1);
    end
    if (push) begin
      vld_d[wr_q]  = 1'b1;
      dead_d[wr_q] = 1'b0;
      wr_d         = wr_q + AW'(1);
    end
    if (alu_eff) begin
      we_d   = 1'b1;
      wreg_d = ALUWriteRegister_IN;
      wdat_d = ALUWriteData_IN;
    end else if (pop && !dead_q[rd_q]) begin
      we_d   = 1'b1;
      wreg_d = reg_q[rd_q];
      wdat_d = dat_q[rd_q];
    end
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + CW'(1);
    end else begin
      starve_d = starve_q;
    end
    stall_d = (starve_d == LIMIT);
  end

  // Pending mask reflects only live, non-dead registered entries
  always_comb begin
    PendingMask_OUT = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !dead_q[i]) begin
        PendingMask_OUT[reg_q[i]] = 1'b1;
      end
    end
  end

  // Control and output registers; reset discards all buffered entries
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      vld_q    <= '0;
      dead_q   <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdat_q   <= '0;
      stall_q  <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      dead_q   <= dead_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdat_q   <= wdat_d;
      stall_q  <= stall_d;
    end
  end

  // Payload storage needs no reset; slots are only read while marked valid
  always_ff @(posedge CLOCK) begin
    if (push) begin
      reg_q[wr_q] <= LongWriteRegister_IN;
      dat_q[wr_q] <= LongWriteData_IN;
    end
  end

  assign WriteEnable_OUT   = we_q;
  assign WriteRegister_OUT = wreg_q;
  assign WriteData_OUT     = wdat_q;
  assign StallReq_OUT      = stall_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb/tb_regfile_writeback_arbiter.sv - vector table plus write-order scoreboard for regfile_writeback_arbiter
module tb_regfile_writeback_arbiter;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        ALUWrite_IN;
  logic [4:0]  ALUWriteRegister_IN;
  logic [31:0] ALUWriteData_IN;
  logic        LongValid_IN;
  logic        LongReady_OUT;
  logic [4:0]  LongWriteRegister_IN;
  logic [31:0] LongWriteData_IN;
  logic        WriteEnable_OUT;
  logic [4:0]  WriteRegister_OUT;
  logic [31:0] WriteData_OUT;
  logic [31:0] PendingMask_OUT;
  logic        StallReq_OUT;

  regfile_writeback_arbiter dut (
    .CLOCK                (CLOCK),
    .RESET                (RESET),
    .ALUWrite_IN          (ALUWrite_IN),
    .ALUWriteRegister_IN  (ALUWriteRegister_IN),
    .ALUWriteData_IN      (ALUWriteData_IN),
    .LongValid_IN         (LongValid_IN),
    .LongReady_OUT        (LongReady_OUT),
    .LongWriteRegister_IN (LongWriteRegister_IN),
    .LongWriteData_IN     (LongWriteData_IN),
    .WriteEnable_OUT      (WriteEnable_OUT),
    .WriteRegister_OUT    (WriteRegister_OUT),
    .WriteData_OUT        (WriteData_OUT),
    .PendingMask_OUT      (PendingMask_OUT),
    .StallReq_OUT         (StallReq_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic        aw;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_dat;
    logic [31:0] e_mask;
    logic        e_stall;
    logic        e_rdy;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input int aw, input int ar, input int ad, input int lv, input int lr,
                              input int ld, input int we, input int rg, input int dt, input int mask,
                              input int stall, input int rdy);
    vec_t v;
    v.aw = aw[0];       v.ar = ar[4:0];     v.ad = 32'(ad);
    v.lv = lv[0];       v.lr = lr[4:0];     v.ld = 32'(ld);
    v.e_we = we[0];     v.e_reg = rg[4:0];  v.e_dat = 32'(dt);
    v.e_mask = 32'(mask); v.e_stall = stall[0]; v.e_rdy = rdy[0];
    return v;
  endfunction

  task automatic drive(input vec_t v);
    wr_t w;
    ALUWrite_IN          = v.aw;
    ALUWriteRegister_IN  = v.ar;
    ALUWriteData_IN      = v.ad;
    LongValid_IN         = v.lv;
    LongWriteRegister_IN = v.lr;
    LongWriteData_IN     = v.ld;
    if (v.e_we) begin
      w.r = v.e_reg;
      w.d = v.e_dat;
      sb.push_back(w);
    end
  endtask

  // Every issued write must match the next expected write in order
  always @(negedge CLOCK) begin
    if (!RESET && WriteEnable_OUT) begin
      if (sb.size() == 0) begin
        check("unexpected_write_reg", 32'(WriteRegister_OUT), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wb_reg", 32'(WriteRegister_OUT), 32'(e.r));
        check("wb_data", WriteData_OUT, e.d);
      end
    end
  end

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(idle);

    vecs.push_back(mk(1, 5, 'h1234, 0, 0, 0,     1, 5, 'h1234, 0, 0, 1));
    vecs.push_back(idle);
    vecs.push_back(mk(0, 0, 0, 1, 7, 'hAAAA,     0, 0, 0, 'h80, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,          1, 7, 'hAAAA, 0, 0, 1));
    vecs.push_back(idle);
    vecs.push_back(mk(1, 0, 'h55, 1, 0, 'h66,    0, 0, 0, 0, 0, 1));
    vecs.push_back(idle);
    vecs.push_back(mk(1, 1, 'h11, 1, 10, 'hA0,   1, 1, 'h11, 'h400, 0, 1));
    vecs.push_back(mk(1, 2, 'h22, 1, 11, 'hA1,   1, 2, 'h22, 'hC00, 0, 1));
    vecs.push_back(mk(1, 3, 'h33, 1, 12, 'hA2,   1, 3, 'h33, 'h1C00, 0, 1));
    vecs.push_back(mk(1, 4, 'h44, 1, 13, 'hA3,   1, 4, 'h44, 'h3C00, 1, 0));
    vecs.push_back(mk(1, 6, 'h66, 1, 14, 'hA4,   1, 6, 'h66, 'h3C00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 14, 'hA4,      1, 10, 'hA0, 'h3800, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 14, 'hA4,      1, 11, 'hA1, 'h7000, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,          1, 12, 'hA2, 'h6000, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,          1, 13, 'hA3, 'h4000, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,          1, 14, 'hA4, 0, 0, 1));
    vecs.push_back(idle);
    vecs.push_back(mk(0, 0, 0, 1, 9, 'h1,        0, 0, 0, 'h200, 0, 1));
`ifdef WB_WAW_SQUASH_EN
    vecs.push_back(mk(1, 9, 'h2, 0, 0, 0,        1, 9, 'h2, 0, 0, 1));
    vecs.push_back(idle);
`else
    vecs.push_back(mk(1, 9, 'h2, 0, 0, 0,        1, 9, 'h2, 'h200, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9, 'h1, 0, 0, 1));
`endif
    vecs.push_back(idle);
    vecs.push_back(mk(1, 1, 'h101, 1, 20, 'hB0, 1, 1, 'h101, 'h100000, 0, 1));
    vecs.push_back(mk(1, 2, 'h102, 1, 21, 'hB1, 1, 2, 'h102, 'h300000, 0, 1));
    vecs.push_back(mk(1, 3, 'h103, 1, 22, 'hB2, 1, 3, 'h103, 'h700000, 0, 1));

    repeat (2) @(posedge CLOCK);
    #1;
    check("rst_we",    32'(WriteEnable_OUT), 32'd0);
    check("rst_reg",   32'(WriteRegister_OUT), 32'd0);
    check("rst_data",  WriteData_OUT, 32'd0);
    check("rst_mask",  PendingMask_OUT, 32'd0);
    check("rst_stall", 32'(StallReq_OUT), 32'd0);
    check("rst_ready", 32'(LongReady_OUT), 32'd0);
    RESET = 1'b0;
    #1;
    check("ready_after_rst", 32'(LongReady_OUT), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge CLOCK);
      #1;
      check($sformatf("v%0d_we", i),    32'(WriteEnable_OUT), 32'(vecs[i].e_we));
      check($sformatf("v%0d_mask", i),  PendingMask_OUT, vecs[i].e_mask);
      check($sformatf("v%0d_stall", i), 32'(StallReq_OUT), 32'(vecs[i].e_stall));
      check($sformatf("v%0d_ready", i), 32'(LongReady_OUT), 32'(vecs[i].e_rdy));
    end

    // Reset with three buffered entries and a write on the port
    drive(idle);
    @(negedge CLOCK);
    #1;
    RESET = 1'b1;
    #1;
    check("midrst_we",    32'(WriteEnable_OUT), 32'd0);
    check("midrst_reg",   32'(WriteRegister_OUT), 32'd0);
    check("midrst_data",  WriteData_OUT, 32'd0);
    check("midrst_mask",  PendingMask_OUT, 32'd0);
    check("midrst_stall", 32'(StallReq_OUT), 32'd0);
    check("midrst_ready", 32'(LongReady_OUT), 32'd0);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLOCK);
      #1;
      check($sformatf("postrst%0d_we", i),   32'(WriteEnable_OUT), 32'd0);
      check($sformatf("postrst%0d_mask", i), PendingMask_OUT, 32'd0);
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_arbiter.md
# regfile_writeback_arbiter

Write-side front end of the processor register file: merges single-cycle writebacks from the pipeline WB stage with write requests from long-latency units (multiply/divide, uncached loads). Long-latency requests are buffered in a small FIFO, and the merged stream is presented as one registered write port (enable/register/data) driving the register file's write inputs. Also exports a per-register pending mask to the hazard unit and a stall request when buffered writes are starved.

## Interface
Parameters:
- DEPTH, 4, long-latency FIFO entries; power of two, ≥2
- STARVE_LIMIT, 3, consecutive blocked cycles before stall request; ≥1

Ports:
- CLOCK  input  1  clock; all state updates on rising edge
- RESET  input  1  asynchronous, active-high reset
- ALUWrite_IN  input  1  WB-stage write request; cannot be back-pressured
- ALUWriteRegister_IN  input  5  WB-stage destination register
- ALUWriteData_IN  input  32  WB-stage write data
- LongValid_IN  input  1  long-latency request valid
- LongReady_OUT  output  1  FIFO can accept; transfer when LongValid_IN & LongReady_OUT
- LongWriteRegister_IN  input  5  long-latency destination register
- LongWriteData_IN  input  32  long-latency write data
- WriteEnable_OUT  output  1  registered write enable to register file
- WriteRegister_OUT  output  5  registered destination register
- WriteData_OUT  output  32  registered write data
- PendingMask_OUT  output  32  bit r set while any live FIFO entry targets r
- StallReq_OUT  output  1  registered request for pipeline to idle WB stage for one cycle

## Operation
- Register 0 is never written: ALU writes to r0 are treated as ALUWrite_IN=0; long requests to r0 complete the handshake but are not enqueued.
- LongReady_OUT = !full, forced 0 while RESET is high. Push only on handshake; a pop in the same cycle does not free space for a push into a full FIFO.
- Arbitration each cycle: an effective ALU write wins. Otherwise, if the FIFO is non-empty, the head is popped and issued.
- Issued write (ALU or head) appears on WriteEnable/Register/Data_OUT the next cycle. Otherwise WriteEnable_OUT=0; Register/Data hold their previous values.
- FIFO entries drain strictly in arrival order.
- PendingMask_OUT is combinational from registered FIFO state only: the OR of one-hot decodes of live entries. An entry is cleared from the mask in the cycle after it pops.
- Starvation counter: increments when the FIFO is non-empty and the head is not popped, saturating at STARVE_LIMIT. Clears on any pop or when the FIFO is empty.
- StallReq_OUT is a flop, set when the counter equals STARVE_LIMIT. The pipeline keeps ALUWrite_IN low in the cycle after it sees StallReq_OUT high. If it does not, the ALU write still wins and nothing is dropped.
- RESET mid-operation empties the FIFO, discarding pending entries, and clears all outputs and the counter immediately.

## Timing
- Reset values: WriteEnable_OUT=0, WriteRegister_OUT=0, WriteData_OUT=0, PendingMask_OUT=0, StallReq_OUT=0, LongReady_OUT=0 (1 in the first cycle after RESET deasserts).
- ALU latency: 1 cycle, from ALUWrite_IN sampled to WriteEnable_OUT.
- Long latency, uncontended: 2 cycles from handshake (enqueue, then pop) to WriteEnable_OUT.
- Throughput: one register-file write per cycle; a full FIFO with no ALU traffic drains in DEPTH cycles.

## Configuration
- WB_WAW_SQUASH_EN defined: an effective ALU write to register r marks every live FIFO entry targeting r dead in the same cycle. Dead entries leave PendingMask_OUT next cycle and are popped without asserting WriteEnable_OUT, consuming one cycle each. The ALU value remains final.
- WB_WAW_SQUASH_EN undefined: FIFO entries always write when popped; WAW ordering is the hazard unit's responsibility (via PendingMask_OUT).

## Test plan
- Reset, then ALU write r5=0x1234 -> next cycle WriteEnable_OUT=1, WriteRegister_OUT=5, WriteData_OUT=0x1234; nothing else.
- Long push r7=0xAAAA with ALU idle -> PendingMask_OUT bit 7 set for one cycle; write appears 2 cycles after handshake; mask clears the following cycle.
- ALU writes every cycle while 4 long requests are pushed (DEPTH=4) -> LongReady_OUT=0 after the 4th; StallReq_OUT=1 after 3 blocked cycles; one ALU-idle cycle pops the head and StallReq_OUT returns to 0.
- ALU write to r0 and long push to r0 -> WriteEnable_OUT stays 0; handshake completes; PendingMask_OUT=0.
- With WB_WAW_SQUASH_EN: long push r9=0x1, then ALU write r9=0x2 while entry is buffered -> only 0x2 is written to r9; entry popped silently. Without the macro: 0x2, then 0x1.
- RESET asserted with 3 FIFO entries and WriteEnable_OUT=1 -> all outputs 0 immediately; no buffered write is issued after release.
